// File: rtl/mult.sv
// mult: sequential shift-add 32x32->64 multiplier (MULT/MULTU), one multiplier bit per clock.
// Define MULT_EARLY_EXIT_EN to leave CALC once the remaining multiplier bits are all zero.
module mult (
  input  logic        clk,
  input  logic        mulrst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signmul,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state_q, state_d;
  logic [63:0] acc_q, mcand_q;
  logic [31:0] mb_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic        accept, last;
  logic [31:0] ma, mbv;
  logic [63:0] sum, res;
  always_comb begin
    accept  = start & (state_q == IDLE || state_q == DONE);
    ma      = (signmul & a[31]) ? -a : a;
    mbv     = (signmul & b[31]) ? -b : b;
    sum     = mb_q[0] ? acc_q + mcand_q : acc_q;
    res     = neg_q ? -acc_q : acc_q;
`ifdef MULT_EARLY_EXIT_EN
    last    = (cnt_q == 5'd31) || (mb_q[31:1] == 31'd0);
`else
    last    = cnt_q == 5'd31;
`endif
    state_d = accept ? CALC :
              state_q == CALC ? (last ? FIX : CALC) :
              state_q == FIX  ? DONE : IDLE;
    busy    = state_q == CALC || state_q == FIX;
    done    = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (mulrst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        mcand_q <= {32'b0, ma};
        mb_q    <= mbv;
        neg_q   <= signmul & (a[31] ^ b[31]);
      end else if (state_q == CALC) begin
        acc_q   <= sum;
        mcand_q <= mcand_q << 1;
        mb_q    <= mb_q >> 1;
        cnt_q   <= cnt_q + 5'd1;
      end else if (state_q == FIX) begin
        acc_q    <= res;
        {hi, lo} <= res;
      end
    end
  end
endmodule

// File: tb/tb_mult.sv
// tb_mult: directed scoreboard bench for mult; expected products and latencies come from a behavioural model.
module tb_mult;
  logic        clk = 0, mulrst = 1, start = 0, signmul = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic        busy, done;
  int          cyc = 0, c0 = 0, vectors = 0, miscompares = 0;
  logic [63:0] sb[$];
  int          lat_q[$];

  mult dut (.clk(clk), .mulrst(mulrst), .start(start), .a(a), .b(b), .signmul(signmul),
            .hi(hi), .lo(lo), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] sx, sy;
    sx = s ? {{32{x[31]}}, x} : {32'b0, x};
    sy = s ? {{32{y[31]}}, y} : {32'b0, y};
    return sx * sy;
  endfunction

  function automatic int lat(input logic [31:0] y, input logic s);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int l;
    m = (s & y[31]) ? -y : y;
    l = 1;
    for (int i = 0; i < 32; i++) if (m[i]) l = i + 1;
    return l + 1;
`else
    return 33;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb2, input logic ts, input logic push);
    a = ta; b = tb2; signmul = ts; start = 1;
    if (push) begin
      sb.push_back(prod(ta, tb2, ts));
      lat_q.push_back(lat(tb2, ts));
    end
    @(negedge clk);
    start = 0;
    c0 = cyc;
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
  endtask

  task automatic finish_op(input string tag);
    logic [63:0] e;
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cyc - c0, lat_q.pop_front());
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic done_falls(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    mulrst = 0;
    @(negedge clk);

    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    finish_op("umax");
    done_falls("umax");

    launch(7, 9, 0, 0);
    repeat (9) @(negedge clk);
    mulrst = 1;
    @(negedge clk);
    mulrst = 0;
    check("rstmid_busy", busy, 0);
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("rstmid_no_done", seen, 0);

    launch(32'hFFFFFFFD, 5, 1, 1);
    finish_op("neg3x5");
    done_falls("neg3x5");

    launch(32'h80000000, 32'h80000000, 1, 1);
    finish_op("smin_sq");
    done_falls("smin_sq");
    launch(32'h80000000, 32'h80000000, 0, 1);
    finish_op("umin_sq");
    done_falls("umin_sq");

    launch(6, 7, 0, 1);
    finish_op("b2b_first");
    launch(0, 32'h12345678, 0, 1);
    check("b2b_hold_lo", lo, 42);
    check("b2b_hold_hi", hi, 0);
    start = 1; a = 9; b = 9;
    @(negedge clk);
    start = 0;
    check("b2b_busy_ignore", busy, 1);
    finish_op("b2b_second");
    done_falls("b2b_second");

    launch(32'h1234, 3, 0, 1);
    finish_op("x1234x3");
    done_falls("x1234x3");
    launch(5, 0, 0, 1);
    finish_op("x5x0");
    done_falls("x5x0");
    launch(32'hDEADBEEF, 32'h87654321, 1, 1);
    finish_op("mixed_signed");
    done_falls("mixed_signed");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
